// File: rtl/avalon_mm_mem_slave.sv
// Avalon-MM responder: local word memory with wait states, byte-enable writes,
// fixed-latency pipelined reads and a saturating protocol/range error counter.
module avalon_mm_mem_slave #(
    parameter int unsigned DEPTH_LOG2   = 8,
    parameter int unsigned WAIT_STATES  = 1,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [31:0] OOR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk_clk,
    input  logic        clk_reset_reset_n,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic [3:0]  slave_byteenable,
    output logic        slave_waitrequest,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    output logic [15:0] err_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned RL    = READ_LATENCY;
    localparam logic [2:0]  WS    = 3'(WAIT_STATES);

    logic [2:0]          wcnt_q, wcnt_d;
    logic [15:0]         err_q, err_d;
    logic [RL-1:0]       pv_q, pv_d;
    logic [RL-1:0][31:0] pd_q, pd_d;
    logic [31:0]         mem [DEPTH];

    logic                  req;
    logic                  accept;
    logic                  stall_abort;
    logic                  in_range;
    logic                  do_write;
    logic                  do_read;
    logic                  err_inc;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rd_word;
    logic [RL:0]           chain_v;
    logic [RL:0][31:0]     chain_d;
    logic                  unused_addr_lsb;

    assign req               = slave_read | slave_write;
    assign slave_waitrequest = req & (wcnt_q != WS);
    assign accept            = req & ~slave_waitrequest;
    assign stall_abort       = ~req & (wcnt_q != 3'd0);

    assign idx             = slave_address[DEPTH_LOG2+1:2];
    assign in_range        = (slave_address[31:DEPTH_LOG2+2] == '0);
    assign unused_addr_lsb = ^slave_address[1:0];

    // A read colliding with a write is dropped; the write still lands.
    assign do_write = accept & slave_write & in_range;
    assign do_read  = accept & slave_read & ~slave_write;

    assign err_inc = stall_abort
                   | (accept & (slave_write ? (slave_read | ~in_range)
                                            : ~in_range));

    assign rd_word = in_range ? mem[idx] : OOR_DATA;
    assign chain_v = {pv_q, do_read};
    assign chain_d = {pd_q, rd_word};

    always_comb begin
        wcnt_d = wcnt_q;
        if (accept || !req) begin
            wcnt_d = 3'd0;
        end else begin
            wcnt_d = wcnt_q + 3'd1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (err_inc && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
    end

    // Data stages only load on a valid entry so the output holds its value.
    always_comb begin
        pv_d = chain_v[RL-1:0];
        pd_d = pd_q;
        for (int i = 0; i < RL; i++) begin
            if (chain_v[i]) begin
                pd_d[i] = chain_d[i];
            end
        end
    end

    always_ff @(posedge clk_clk or negedge clk_reset_reset_n) begin
        if (!clk_reset_reset_n) begin
            wcnt_q <= 3'd0;
            err_q  <= 16'd0;
            pv_q   <= '0;
            pd_q   <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
            pv_q   <= pv_d;
            pd_q   <= pd_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (do_write && clk_reset_reset_n) begin
            for (int i = 0; i < 4; i++) begin
                if (slave_byteenable[i]) begin
                    mem[idx][8*i +: 8] <= slave_writedata[8*i +: 8];
                end
            end
        end
    end

    assign slave_readdatavalid = pv_q[RL-1];
    assign slave_readdata      = pd_q[RL-1];
    assign err_count           = err_q;

endmodule

// File: tb/tb_avalon_mm_mem_slave.sv
// Self-checking bench for avalon_mm_mem_slave: two instances (default timing
// and zero-wait/latency-1) checked against an array-based behavioural model.
module tb_avalon_mm_mem_slave;

    localparam int WS  = 1;
    localparam int RL  = 2;
    localparam int RL0 = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic [3:0]  be    = '0;
    logic        wreq, rdv;
    logic [31:0] rdata;
    logic [15:0] errc;

    logic [31:0] addr0  = '0;
    logic [31:0] wdata0 = '0;
    logic        rd0    = 1'b0;
    logic        wr0    = 1'b0;
    logic [3:0]  be0    = '0;
    logic        wreq0, rdv0;
    logic [31:0] rdata0;
    logic [15:0] errc0;

    avalon_mm_mem_slave #(
        .DEPTH_LOG2(8), .WAIT_STATES(WS), .READ_LATENCY(RL),
        .OOR_DATA(32'hDEADBEEF)
    ) dut (
        .clk_clk(clk), .clk_reset_reset_n(rst_n),
        .slave_address(addr), .slave_read(rd), .slave_write(wr),
        .slave_writedata(wdata), .slave_byteenable(be),
        .slave_waitrequest(wreq), .slave_readdata(rdata),
        .slave_readdatavalid(rdv), .err_count(errc)
    );

    avalon_mm_mem_slave #(
        .DEPTH_LOG2(4), .WAIT_STATES(0), .READ_LATENCY(RL0),
        .OOR_DATA(32'hCAFEF00D)
    ) dut0 (
        .clk_clk(clk), .clk_reset_reset_n(rst_n),
        .slave_address(addr0), .slave_read(rd0), .slave_write(wr0),
        .slave_writedata(wdata0), .slave_byteenable(be0),
        .slave_waitrequest(wreq0), .slave_readdata(rdata0),
        .slave_readdatavalid(rdv0), .err_count(errc0)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          mq_cyc[$];
    logic [31:0] mq_dat[$];
    int          m0_cyc[$];
    logic [31:0] m0_dat[$];

    always @(negedge clk) begin
        if (rdv === 1'b1) begin
            mq_cyc.push_back(cyc);
            mq_dat.push_back(rdata);
        end
        if (rdv0 === 1'b1) begin
            m0_cyc.push_back(cyc);
            m0_dat.push_back(rdata0);
        end
    end

    logic [31:0] mmem [256];
    bit          mknown [256];
    int          merr = 0;
    logic [31:0] mmem0 [16];
    int          merr0 = 0;

    int          eq_cyc[$];
    logic [31:0] eq_dat[$];
    bit          eq_chk[$];
    int          e0_cyc[$];
    logic [31:0] e0_dat[$];

    task automatic xfer(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output int st, output int acc);
        int ix;
        bit inr;
        st = 0;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d; be = b;
        #1;
        while (wreq !== 1'b0 && st < 16) begin
            st++;
            @(negedge clk);
            #1;
        end
        acc = cyc;
        inr = (a < 32'h400);
        ix  = int'(a[9:2]);
        if (w) begin
            if (inr) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mmem[ix][8*i +: 8] = d[8*i +: 8];
                if (b == 4'hF) mknown[ix] = 1'b1;
            end
            if ((r || !inr) && merr < 65535) merr++;
        end else if (r) begin
            eq_cyc.push_back(acc + RL);
            eq_dat.push_back(inr ? mmem[ix] : 32'hDEADBEEF);
            eq_chk.push_back(!inr || mknown[ix]);
            if (!inr && merr < 65535) merr++;
        end
    endtask

    task automatic xfer0(input bit r, input logic [31:0] a,
                         input logic [31:0] d, output int st, output int acc);
        int ix;
        bit inr;
        st = 0;
        @(negedge clk);
        rd0 = r; wr0 = !r; addr0 = a; wdata0 = d; be0 = 4'hF;
        #1;
        while (wreq0 !== 1'b0 && st < 16) begin
            st++;
            @(negedge clk);
            #1;
        end
        acc = cyc;
        inr = (a < 32'h40);
        ix  = int'(a[5:2]);
        if (!r) begin
            if (inr) mmem0[ix] = d;
            else if (merr0 < 65535) merr0++;
        end else begin
            e0_cyc.push_back(acc + RL0);
            e0_dat.push_back(inr ? mmem0[ix] : 32'hCAFEF00D);
            if (!inr && merr0 < 65535) merr0++;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (rdv !== 1'b0 || rdata !== 32'h0 || errc !== 16'h0 || wreq !== 1'b0) begin
            failures++;
            $display("FAIL reset_state rdv=%b rdata=%h err=%h wreq=%b want 0/0/0/0",
                     rdv, rdata, errc, wreq);
        end
        checks++;
        if (rdv0 !== 1'b0 || rdata0 !== 32'h0 || errc0 !== 16'h0) begin
            failures++;
            $display("FAIL reset_state0 rdv=%b rdata=%h err=%h want 0/0/0",
                     rdv0, rdata0, errc0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int st, acc, gc, ec;
        logic [31:0] gd, ed;
        bit ck;
        xfer(0, 1, 32'h10, 32'h12345678, 4'hF, st, acc);
        checks++;
        if (st != WS) begin
            failures++;
            $display("FAIL basic_write_stall got=%0d want=%0d", st, WS);
        end
        xfer(1, 0, 32'h10, 32'h0, 4'h0, st, acc);
        checks++;
        if (st != WS) begin
            failures++;
            $display("FAIL basic_read_stall got=%0d want=%0d", st, WS);
        end
        idle(RL + 3);
        checks++;
        if (mq_cyc.size() != eq_cyc.size()) begin
            failures++;
            $display("FAIL basic_rdv_count got=%0d want=%0d", mq_cyc.size(), eq_cyc.size());
        end
        while (mq_cyc.size() > 0 && eq_cyc.size() > 0) begin
            gc = mq_cyc.pop_front(); gd = mq_dat.pop_front();
            ec = eq_cyc.pop_front(); ed = eq_dat.pop_front(); ck = eq_chk.pop_front();
            checks++;
            if (gc != ec || (ck && gd !== ed)) begin
                failures++;
                $display("FAIL basic_read cyc=%0d data=%h want cyc=%0d data=%h", gc, gd, ec, ed);
            end
        end
        mq_cyc.delete(); mq_dat.delete();
        eq_cyc.delete(); eq_dat.delete(); eq_chk.delete();
        checks++;
        if (errc !== 16'(merr)) begin
            failures++;
            $display("FAIL basic_err got=%0d want=%0d", errc, merr);
        end
    endtask

    task automatic test_byte_enable();
        int st, acc, gc, ec;
        logic [31:0] gd, ed;
        bit ck;
        xfer(0, 1, 32'h20, 32'hFFFFFFFF, 4'hF, st, acc);
        xfer(0, 1, 32'h20, 32'h00AA0000, 4'b0100, st, acc);
        xfer(1, 0, 32'h22, 32'h0, 4'h0, st, acc);
        xfer(0, 1, 32'h24, 32'h01020304, 4'hF, st, acc);
        xfer(0, 1, 32'h24, 32'hFFFFFFFF, 4'h0, st, acc);
        xfer(0, 1, 32'h24, 32'hEEEEEEEE, 4'b1001, st, acc);
        xfer(1, 0, 32'h24, 32'h0, 4'h0, st, acc);
        idle(RL + 3);
        checks++;
        if (mq_cyc.size() != eq_cyc.size()) begin
            failures++;
            $display("FAIL be_rdv_count got=%0d want=%0d", mq_cyc.size(), eq_cyc.size());
        end
        while (mq_cyc.size() > 0 && eq_cyc.size() > 0) begin
            gc = mq_cyc.pop_front(); gd = mq_dat.pop_front();
            ec = eq_cyc.pop_front(); ed = eq_dat.pop_front(); ck = eq_chk.pop_front();
            checks++;
            if (gc != ec || (ck && gd !== ed)) begin
                failures++;
                $display("FAIL be_read cyc=%0d data=%h want cyc=%0d data=%h", gc, gd, ec, ed);
            end
        end
        mq_cyc.delete(); mq_dat.delete();
        eq_cyc.delete(); eq_dat.delete(); eq_chk.delete();
    endtask

    task automatic test_out_of_range();
        int st, acc, gc, ec, n_rdv;
        logic [31:0] gd, ed;
        bit ck;
        xfer(0, 1, 32'h0, 32'h11112222, 4'hF, st, acc);
        xfer(1, 0, 32'h400, 32'h0, 4'h0, st, acc);
        xfer(0, 1, 32'h400, 32'h55555555, 4'hF, st, acc);
        xfer(1, 0, 32'h0, 32'h0, 4'h0, st, acc);
        idle(RL + 2);
        checks++;
        if (errc !== 16'(merr)) begin
            failures++;
            $display("FAIL oor_err2 got=%0d want=%0d", errc, merr);
        end
        n_rdv = mq_cyc.size();
        xfer(1, 1, 32'h0, 32'h77778888, 4'hF, st, acc);
        idle(RL + 3);
        checks++;
        if (mq_cyc.size() != n_rdv || errc !== 16'(merr)) begin
            failures++;
            $display("FAIL rw_collision rdv_count=%0d err=%0d want %0d/%0d",
                     mq_cyc.size(), errc, n_rdv, merr);
        end
        xfer(1, 0, 32'h0, 32'h0, 4'h0, st, acc);
        xfer(1, 0, 32'h80000010, 32'h0, 4'h0, st, acc);
        idle(RL + 3);
        checks++;
        if (mq_cyc.size() != eq_cyc.size()) begin
            failures++;
            $display("FAIL oor_rdv_count got=%0d want=%0d", mq_cyc.size(), eq_cyc.size());
        end
        while (mq_cyc.size() > 0 && eq_cyc.size() > 0) begin
            gc = mq_cyc.pop_front(); gd = mq_dat.pop_front();
            ec = eq_cyc.pop_front(); ed = eq_dat.pop_front(); ck = eq_chk.pop_front();
            checks++;
            if (gc != ec || (ck && gd !== ed)) begin
                failures++;
                $display("FAIL oor_read cyc=%0d data=%h want cyc=%0d data=%h", gc, gd, ec, ed);
            end
        end
        mq_cyc.delete(); mq_dat.delete();
        eq_cyc.delete(); eq_dat.delete(); eq_chk.delete();
        checks++;
        if (errc !== 16'(merr)) begin
            failures++;
            $display("FAIL oor_err_final got=%0d want=%0d", errc, merr);
        end
    endtask

    task automatic test_violation();
        @(negedge clk);
        rd = 1'b1; addr = 32'h10;
        #1;
        checks++;
        if (wreq !== 1'b1) begin
            failures++;
            $display("FAIL violation_stall wreq=%b want 1", wreq);
        end
        @(negedge clk);
        rd = 1'b0;
        if (merr < 65535) merr++;
        repeat (RL + 3) @(negedge clk);
        checks++;
        if (errc !== 16'(merr) || mq_cyc.size() != 0) begin
            failures++;
            $display("FAIL violation_err err=%0d rdv_count=%0d want %0d/0",
                     errc, mq_cyc.size(), merr);
        end
        mq_cyc.delete(); mq_dat.delete();
    endtask

    task automatic test_reset_mid();
        int st, acc, gc, ec;
        logic [31:0] gd, ed;
        bit ck;
        xfer(0, 1, 32'h14, 32'hA5A55A5A, 4'hF, st, acc);
        xfer(0, 1, 32'h1000, 32'h1, 4'hF, st, acc);
        xfer(1, 0, 32'h14, 32'h0, 4'h0, st, acc);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (errc !== 16'h0 || rdv !== 1'b0 || errc0 !== 16'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs err=%0d rdv=%b err0=%0d want 0/0/0",
                     errc, rdv, errc0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        merr = 0; merr0 = 0;
        eq_cyc.delete(); eq_dat.delete(); eq_chk.delete();
        repeat (RL + 4) @(negedge clk);
        checks++;
        if (mq_cyc.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_flush rdv_count=%0d want 0", mq_cyc.size());
        end
        mq_cyc.delete(); mq_dat.delete();
        xfer(1, 0, 32'h14, 32'h0, 4'h0, st, acc);
        idle(RL + 3);
        checks++;
        if (mq_cyc.size() != eq_cyc.size()) begin
            failures++;
            $display("FAIL reset_rdv_count got=%0d want=%0d", mq_cyc.size(), eq_cyc.size());
        end
        while (mq_cyc.size() > 0 && eq_cyc.size() > 0) begin
            gc = mq_cyc.pop_front(); gd = mq_dat.pop_front();
            ec = eq_cyc.pop_front(); ed = eq_dat.pop_front(); ck = eq_chk.pop_front();
            checks++;
            if (gc != ec || (ck && gd !== ed)) begin
                failures++;
                $display("FAIL reset_mem_intact cyc=%0d data=%h want cyc=%0d data=%h",
                         gc, gd, ec, ed);
            end
        end
        mq_cyc.delete(); mq_dat.delete();
        eq_cyc.delete(); eq_dat.delete(); eq_chk.delete();
        checks++;
        if (errc !== 16'h0) begin
            failures++;
            $display("FAIL reset_err got=%0d want=0", errc);
        end
    endtask

    task automatic test_zero_wait();
        int st, acc, acc0, gc, ec;
        logic [31:0] gd, ed;
        for (int i = 0; i < 4; i++) begin
            xfer0(0, 32'(i * 4), $urandom, st, acc);
            checks++;
            if (st != 0) begin
                failures++;
                $display("FAIL zw_write_stall word=%0d got=%0d want=0", i, st);
            end
        end
        for (int i = 0; i < 4; i++) begin
            xfer0(1, 32'(i * 4), 32'h0, st, acc);
            if (i == 0) acc0 = acc;
            checks++;
            if (st != 0 || acc != acc0 + i) begin
                failures++;
                $display("FAIL zw_read_accept word=%0d stall=%0d cyc=%0d want 0/%0d",
                         i, st, acc, acc0 + i);
            end
        end
        xfer0(1, 32'h40, 32'h0, st, acc);
        idle(RL0 + 3);
        checks++;
        if (m0_cyc.size() != e0_cyc.size()) begin
            failures++;
            $display("FAIL zw_rdv_count got=%0d want=%0d", m0_cyc.size(), e0_cyc.size());
        end
        while (m0_cyc.size() > 0 && e0_cyc.size() > 0) begin
            gc = m0_cyc.pop_front(); gd = m0_dat.pop_front();
            ec = e0_cyc.pop_front(); ed = e0_dat.pop_front();
            checks++;
            if (gc != ec || gd !== ed) begin
                failures++;
                $display("FAIL zw_read cyc=%0d data=%h want cyc=%0d data=%h", gc, gd, ec, ed);
            end
        end
        m0_cyc.delete(); m0_dat.delete();
        e0_cyc.delete(); e0_dat.delete();
        checks++;
        if (errc0 !== 16'(merr0)) begin
            failures++;
            $display("FAIL zw_err got=%0d want=%0d", errc0, merr0);
        end
    endtask

    task automatic test_random();
        int st, acc, k, gap, gc, ec;
        logic [31:0] a, gd, ed;
        bit ck;
        for (int i = 0; i < 16; i++)
            xfer(0, 1, 32'(i * 4), $urandom, 4'hF, st, acc);
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0)
                a = $urandom | 32'h400;
            else
                a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            k = $urandom_range(0, 19);
            if (k < 9)
                xfer(1, 0, a, 32'h0, 4'h0, st, acc);
            else if (k < 19)
                xfer(0, 1, a, $urandom, 4'($urandom_range(0, 15)), st, acc);
            else
                xfer(1, 1, a, $urandom, 4'hF, st, acc);
            checks++;
            if (st != WS) begin
                failures++;
                $display("FAIL rand_stall op=%0d got=%0d want=%0d", n, st, WS);
            end
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap - 1);
        end
        idle(RL + 3);
        checks++;
        if (mq_cyc.size() != eq_cyc.size()) begin
            failures++;
            $display("FAIL rand_rdv_count got=%0d want=%0d", mq_cyc.size(), eq_cyc.size());
        end
        while (mq_cyc.size() > 0 && eq_cyc.size() > 0) begin
            gc = mq_cyc.pop_front(); gd = mq_dat.pop_front();
            ec = eq_cyc.pop_front(); ed = eq_dat.pop_front(); ck = eq_chk.pop_front();
            checks++;
            if (gc != ec || (ck && gd !== ed)) begin
                failures++;
                $display("FAIL rand_read cyc=%0d data=%h want cyc=%0d data=%h", gc, gd, ec, ed);
            end
        end
        mq_cyc.delete(); mq_dat.delete();
        eq_cyc.delete(); eq_dat.delete(); eq_chk.delete();
        checks++;
        if (errc !== 16'(merr)) begin
            failures++;
            $display("FAIL rand_err got=%0d want=%0d", errc, merr);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        wr0 = 1'b1; rd0 = 1'b0; addr0 = 32'h100; wdata0 = 32'h0; be0 = 4'hF;
        repeat (65533) @(negedge clk);
        merr0 = (merr0 + 65533 > 65535) ? 65535 : merr0 + 65533;
        checks++;
        if (errc0 !== 16'(merr0)) begin
            failures++;
            $display("FAIL sat_near got=%0d want=%0d", errc0, merr0);
        end
        repeat (7) @(negedge clk);
        wr0 = 1'b0;
        merr0 = (merr0 + 7 > 65535) ? 65535 : merr0 + 7;
        @(negedge clk);
        checks++;
        if (errc0 !== 16'(merr0) || errc0 !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hold got=%h want=%h", errc0, 16'hFFFF);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_enable();
        test_out_of_range();
        test_violation();
        test_reset_mid();
        test_zero_wait();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
